if_id_skid_reg: RTL and testbench

Fetch-to-decode pipeline register for the 32-bit processor. Holds fetched instructions in a 2-entry skid buffer with a valid/ready handshake. Presents decoded MIPS-style fields, including the raw 16-bit immediate that feeds the 16-to-32 sign-extension stage directly downstream. Supports flush on branch/jump redirect.

---
 rtl/if_id_skid_reg.sv | 127 ++++++++++++
 tb/tb_if_id_skid_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// Fetch-to-decode pipeline register: 2-entry skid buffer with valid/ready handshake and decoded MIPS fields.
// Optional macro NOP_SQUASH_EN: all-zero instruction words are accepted but never enqueued.
module if_id_skid_reg #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         out_opcode,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_shamt,
  output logic [5:0]         out_funct,
  output logic [15:0]        out_imm16,
  output logic [1:0]         occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic               in_ready_q;
  logic               in_fire;
  logic               out_fire;
  logic               push;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = (state_q != EMPTY) & out_ready;

`ifdef NOP_SQUASH_EN
  // A squashed NOP still completes its handshake; it simply never occupies a slot.
  assign push = in_fire & (in_instr != '0);
`else
  assign push = in_fire;
`endif

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (push && out_fire) begin
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
          end else if (push) begin
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
            state_d      = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (out_fire) begin
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
            state_d      = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= (state_d != TWO);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign occupancy  = state_q;
  assign out_instr  = main_instr_q;
  assign out_pc     = main_pc_q;
  assign out_opcode = main_instr_q[31:26];
  assign out_rs     = main_instr_q[25:21];
  assign out_rt     = main_instr_q[20:16];
  assign out_rd     = main_instr_q[15:11];
  assign out_shamt  = main_instr_q[10:6];
  assign out_funct  = main_instr_q[5:0];
  assign out_imm16  = main_instr_q[15:0];

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: directed plan plus random traffic against a queue-based FIFO model.
// Honours NOP_SQUASH_EN the same way the design does.
module tb_if_id_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm16;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  logic [31:0] qInstr[$];
  logic [31:0] qPc[$];
  logic        modelInReady;

  if_id_skid_reg #(.INSTR_W(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    qInstr.delete();
    qPc.delete();
    modelInReady = 1'b0;
  endtask

  // FIFO semantics: flush wins, otherwise pop the head and append an accepted word.
  task automatic modelEdge();
    bit accept;
    bit pop;
    if (flush) begin
      qInstr.delete();
      qPc.delete();
    end else begin
      accept = in_valid && modelInReady;
      pop    = (qInstr.size() > 0) && out_ready;
      if (pop) begin
        void'(qInstr.pop_front());
        void'(qPc.pop_front());
      end
`ifdef NOP_SQUASH_EN
      if (accept && in_instr == 32'h0) accept = 1'b0;
`endif
      if (accept) begin
        qInstr.push_back(in_instr);
        qPc.push_back(in_pc);
      end
    end
    modelInReady = (qInstr.size() < 2);
  endtask

  task automatic checkState(input string tag);
    logic [31:0] e;
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(qInstr.size() > 0));
    checkOutput({tag, ".occupancy"}, 32'(occupancy), 32'(qInstr.size()));
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(modelInReady));
    if (qInstr.size() > 0) begin
      e = qInstr[0];
      checkOutput({tag, ".instr"}, out_instr, e);
      checkOutput({tag, ".pc"}, out_pc, qPc[0]);
      checkOutput({tag, ".opcode"}, 32'(out_opcode), 32'(e[31:26]));
      checkOutput({tag, ".rs"}, 32'(out_rs), 32'(e[25:21]));
      checkOutput({tag, ".rt"}, 32'(out_rt), 32'(e[20:16]));
      checkOutput({tag, ".rd"}, 32'(out_rd), 32'(e[15:11]));
      checkOutput({tag, ".shamt"}, 32'(out_shamt), 32'(e[10:6]));
      checkOutput({tag, ".funct"}, 32'(out_funct), 32'(e[5:0]));
      checkOutput({tag, ".imm16"}, 32'(out_imm16), 32'(e[15:0]));
    end
  endtask

  // Drives one cycle of inputs, advances the model at the edge, then checks 1 time unit later.
  task automatic applyStimulus(input string tag, input logic v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    modelEdge();
    #1;
    checkState(tag);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    out_ready = 1'b0;
    modelReset();

    #12;
    checkOutput("reset.out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset.in_ready", 32'(in_ready), 32'h0);
    checkOutput("reset.occupancy", 32'(occupancy), 32'h0);
    checkOutput("reset.instr", out_instr, 32'h0);
    checkOutput("reset.imm16", 32'(out_imm16), 32'h0);
    rst = 1'b0;

    // 1. first edge after release only raises in_ready; then a single push
    applyStimulus("t1.idle", 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    applyStimulus("t1.push", 1'b1, 32'h2009FFFC, 32'h00400000, 1'b0, 1'b0);
    checkOutput("t1.opcode", 32'(out_opcode), 32'h08);
    checkOutput("t1.rs", 32'(out_rs), 32'h0);
    checkOutput("t1.rt", 32'(out_rt), 32'h9);
    checkOutput("t1.imm16", 32'(out_imm16), 32'hFFFC);
    checkOutput("t1.occupancy", 32'(occupancy), 32'h1);
    applyStimulus("t1.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // 2. backpressure fill, rejected third word, then drain
    applyStimulus("t2.push1", 1'b1, 32'h11111111, 32'h100, 1'b0, 1'b0);
    applyStimulus("t2.push2", 1'b1, 32'h22222222, 32'h104, 1'b0, 1'b0);
    checkOutput("t2.full_in_ready", 32'(in_ready), 32'h0);
    applyStimulus("t2.push3", 1'b1, 32'h33333333, 32'h108, 1'b0, 1'b0);
    checkOutput("t2.head", out_instr, 32'h11111111);
    applyStimulus("t2.pop1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t2.second", out_instr, 32'h22222222);
    applyStimulus("t2.pop2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t2.empty", 32'(out_valid), 32'h0);

    // 3. streaming at one word per cycle
    for (int i = 0; i < 8; i++) begin
      applyStimulus("t3.stream", 1'b1, 32'(i), 32'(32'h200 + 4 * i), 1'b1, 1'b0);
      checkOutput("t3.word", out_instr, 32'(i));
      checkOutput("t3.occ", 32'(occupancy), 32'h1);
    end
    applyStimulus("t3.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // 4. flush colliding with input and output transfers
    applyStimulus("t4.fill1", 1'b1, 32'hA1A1A1A1, 32'h300, 1'b0, 1'b0);
    applyStimulus("t4.fill2", 1'b1, 32'hB2B2B2B2, 32'h304, 1'b0, 1'b0);
    applyStimulus("t4.flush", 1'b1, 32'hC3C3C3C3, 32'h308, 1'b1, 1'b1);
    checkOutput("t4.out_valid", 32'(out_valid), 32'h0);
    checkOutput("t4.in_ready", 32'(in_ready), 32'h1);
    applyStimulus("t4.after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("t4.dropped", 32'(out_valid), 32'h0);

    // 5. asynchronous reset between edges while full
    applyStimulus("t5.fill1", 1'b1, 32'h55550001, 32'h400, 1'b0, 1'b0);
    applyStimulus("t5.fill2", 1'b1, 32'h55550002, 32'h404, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("t5.async_valid", 32'(out_valid), 32'h0);
    checkOutput("t5.async_occ", 32'(occupancy), 32'h0);
    checkOutput("t5.async_in_ready", 32'(in_ready), 32'h0);
    #2 rst = 1'b0;
    applyStimulus("t5.idle", 1'b1, 32'h77777777, 32'h0, 1'b1, 1'b0);
    applyStimulus("t5.push", 1'b1, 32'hAC0A0010, 32'h500, 1'b0, 1'b0);
    checkOutput("t5.imm16", 32'(out_imm16), 32'h0010);
    applyStimulus("t5.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // 6. zero word followed by an R-type add
    applyStimulus("t6.zero", 1'b1, 32'h00000000, 32'h600, 1'b1, 1'b0);
    applyStimulus("t6.add", 1'b1, 32'h00851020, 32'h604, 1'b1, 1'b0);
    applyStimulus("t6.drain1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6.funct", 32'(out_funct), 32'h20);
    checkOutput("t6.rd", 32'(out_rd), 32'h2);
    applyStimulus("t6.drain2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional zero words and flushes
    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      w = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      applyStimulus("rand", 1'($urandom_range(0, 1)), w, $urandom,
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
